// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first serialiser with runtime divisor, parity and stop bits.
// Data and configuration are latched when a word is accepted, so the frame in flight cannot be disturbed.
module uart_tx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DIV_W-1:0]  cfg_baud_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state_dbg
);

  localparam int DEFAULT_DIV = CLK_FREQ / BAUD_RATE;

  if (DATA_W < 5 || DATA_W > 9 || DEFAULT_DIV < 2 || DEFAULT_DIV >= (1 << DIV_W)) begin : g_bad_params
    $error("uart_tx_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  function automatic logic parity_bit(input logic [1:0] mode, input logic [DATA_W-1:0] data);
    logic even;
    even = ^data;
    case (mode)
      PAR_EVEN: parity_bit = even;
      PAR_ODD:  parity_bit = ~even;
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = 1'b1;
    endcase
  endfunction

  state_t            state_r, state_s;
  logic [DATA_W-1:0] data_r, shift_r;
  logic [DIV_W-1:0]  div_r, cnt_r, eff_div_s;
  logic [1:0]        par_r;
  logic              stop2_r;
  logic [3:0]        bit_idx_r;
  logic              accept_s, bit_end_s, last_bit_s;
  logic              tx_s, busy_s, ready_s, done_s;
  logic              tx_r, busy_r, ready_r, done_r;

  // Divisors below 2 would make a bit shorter than the handshake can track.
  assign eff_div_s  = (cfg_baud_div < DIV_W'(2)) ? DIV_W'(2) : cfg_baud_div;
  assign accept_s   = (state_r == ST_IDLE) && s_valid && ready_r;
  assign bit_end_s  = (state_r != ST_IDLE) && (cnt_r == div_r - DIV_W'(1));
  assign last_bit_s = (bit_idx_r == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; every non-IDLE transition waits for the end of the current bit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) state_s = ST_DATA;
        else           state_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && last_bit_s) begin
          if (par_r != PAR_NONE) state_s = ST_PARITY;
          else                   state_s = ST_STOP1;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) state_s = ST_STOP1;
        else           state_s = ST_PARITY;
      end
      ST_STOP1: begin
        if (bit_end_s) begin
          if (stop2_r) state_s = ST_STOP2;
          else         state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (bit_end_s) state_s = ST_IDLE;
        else           state_s = ST_STOP2;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Shadow registers, baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= '0;
      shift_r   <= '0;
      div_r     <= '0;
      cnt_r     <= '0;
      par_r     <= 2'b00;
      stop2_r   <= 1'b0;
      bit_idx_r <= 4'd0;
    end else if (accept_s) begin
      data_r    <= s_data;
      shift_r   <= s_data;
      div_r     <= eff_div_s;
      cnt_r     <= '0;
      par_r     <= cfg_parity;
      stop2_r   <= cfg_stop2;
      bit_idx_r <= 4'd0;
    end else if (state_r != ST_IDLE) begin
      if (bit_end_s) begin
        cnt_r <= '0;
        if (state_r == ST_DATA) begin
          shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
          bit_idx_r <= bit_idx_r + 4'd1;
        end
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_IDLE:  tx_s = 1'b1;
      ST_START: tx_s = 1'b0;
      ST_DATA: begin
        if ((state_r == ST_DATA) && bit_end_s) tx_s = shift_r[1];
        else                                   tx_s = shift_r[0];
      end
      ST_PARITY: tx_s = parity_bit(par_r, data_r);
      ST_STOP1:  tx_s = 1'b1;
      ST_STOP2:  tx_s = 1'b1;
      default:   tx_s = 1'b1;
    endcase
    busy_s  = (state_s != ST_IDLE);
    ready_s = (state_s == ST_IDLE);
    done_s  = ((state_r == ST_STOP1) || (state_r == ST_STOP2)) && (state_s == ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
      done_r  <= done_s;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign s_ready    = ready_r;
  assign frame_done = done_r;
  assign state_dbg  = state_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: 8-bit and 9-bit builds checked against a frame-level bit model.
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  din = 9'd0;
  logic        vin = 1'b0;
  logic        sel9 = 1'b0;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_par = 2'd0;
  logic        cfg_st2 = 1'b0;

  logic rdy8, tx8, busy8, fd8;
  logic rdy9, tx9, busy9, fd9;
  logic [2:0] st8, st9;
  logic rdy_o, tx_o, busy_o, fd_o;
  logic [2:0] st_o;

  int total = 0;
  int bad = 0;

  bit         exp_tx[$];
  logic [2:0] exp_st[$];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .s_data(din[7:0]), .s_valid(vin & ~sel9), .s_ready(rdy8),
    .cfg_baud_div(cfg_div), .cfg_parity(cfg_par), .cfg_stop2(cfg_st2),
    .tx(tx8), .busy(busy8), .frame_done(fd8), .state_dbg(st8)
  );

  uart_tx_param #(.DATA_W(9)) dut9 (
    .clk(clk), .rst(rst), .s_data(din), .s_valid(vin & sel9), .s_ready(rdy9),
    .cfg_baud_div(cfg_div), .cfg_parity(cfg_par), .cfg_stop2(cfg_st2),
    .tx(tx9), .busy(busy9), .frame_done(fd9), .state_dbg(st9)
  );

  assign rdy_o  = sel9 ? rdy9 : rdy8;
  assign tx_o   = sel9 ? tx9 : tx8;
  assign busy_o = sel9 ? busy9 : busy8;
  assign fd_o   = sel9 ? fd9 : fd8;
  assign st_o   = sel9 ? st9 : st8;

  // Frame model: list of bit values with their state codes, each repeated N clocks.
  task automatic build_model(input logic [8:0] data, input int div, input logic [1:0] par, input logic st2);
    int n, dw, ones;
    bit bits[$];
    int codes[$];
    n = (div < 2) ? 2 : div;
    dw = sel9 ? 9 : 8;
    ones = 0;
    bits.push_back(1'b0); codes.push_back(1);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]); codes.push_back(2);
      if (data[i]) ones++;
    end
    if (par == 2'd1) begin bits.push_back(ones % 2 == 1); codes.push_back(3); end
    if (par == 2'd2) begin bits.push_back(ones % 2 == 0); codes.push_back(3); end
    if (par == 2'd3) begin bits.push_back(1'b1);          codes.push_back(3); end
    bits.push_back(1'b1); codes.push_back(4);
    if (st2) begin bits.push_back(1'b1); codes.push_back(5); end
    exp_tx.delete();
    exp_st.delete();
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < n; k++) begin
        exp_tx.push_back(bits[b]);
        exp_st.push_back(3'(codes[b]));
      end
    end
  endtask

  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rdy_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s ready_timeout: s_ready=%b, expected 1 within 500 cycles", name, rdy_o);
    end
  endtask

  task automatic run_frame(input string name, input logic [8:0] data, input int div,
                           input logic [1:0] par, input logic st2, input bit mid_change);
    bit ok;
    int tx_err, st_err, hs_err, first;
    logic got_tx, want_tx;
    build_model(data, div, par, st2);
    wait_ready(name, ok);
    if (!ok) return;
    din = data; cfg_div = 16'(div); cfg_par = par; cfg_st2 = st2; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    din = 9'($urandom);
    cfg_div = mid_change ? 16'd10 : 16'($urandom_range(0, 20));
    cfg_par = 2'($urandom);
    cfg_st2 = 1'($urandom);
    tx_err = 0; st_err = 0; hs_err = 0; first = -1; got_tx = 1'b0; want_tx = 1'b0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      if (tx_o !== exp_tx[i]) begin
        if (first < 0) begin first = i; got_tx = tx_o; want_tx = exp_tx[i]; end
        tx_err++;
      end
      if (st_o !== exp_st[i]) st_err++;
      if (busy_o !== 1'b1 || fd_o !== 1'b0 || rdy_o !== 1'b0) hs_err++;
    end
    total++;
    if (tx_err != 0) begin
      bad++;
      $display("FAIL %s tx_wave: %0d of %0d cycles wrong, first at cycle %0d got %b expected %b",
               name, tx_err, exp_tx.size(), first, got_tx, want_tx);
    end
    total++;
    if (st_err != 0) begin
      bad++;
      $display("FAIL %s state_seq: %0d cycles with wrong state_dbg, expected 0", name, st_err);
    end
    total++;
    if (hs_err != 0) begin
      bad++;
      $display("FAIL %s busy_in_frame: %0d cycles with busy/frame_done/s_ready wrong, expected 0", name, hs_err);
    end
    @(negedge clk);
    total++;
    if ({fd_o, busy_o, tx_o, rdy_o, st_o} !== 7'b1011000) begin
      bad++;
      $display("FAIL %s end_of_frame: {done,busy,tx,ready,state}=%b expected 1011000",
               name, {fd_o, busy_o, tx_o, rdy_o, st_o});
    end
    @(negedge clk);
    total++;
    if (fd_o !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width: frame_done=%b on second idle cycle, expected 0", name, fd_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx8, busy8, rdy8, fd8, st8, tx9, busy9, rdy9, fd9, st9} !== 14'b1000000_1000000) begin
      bad++;
      $display("FAIL reset_state: got %b expected 10000001000000",
               {tx8, busy8, rdy8, fd8, st8, tx9, busy9, rdy9, fd9, st9});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy8, rdy9, busy8, busy9} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_release: {rdy8,rdy9,busy8,busy9}=%b expected 1100", {rdy8, rdy9, busy8, busy9});
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] words[3];
    bit ok, rb;
    int idx, since, cyc, len, tx_err, fd_err;
    bit exp_all[$];
    bit tx_rec[$];
    bit fd_rec[$];
    int acc_at[3];
    bit want_fd;
    words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
    sel9 = 1'b0;
    len = 0;
    for (int w = 0; w < 3; w++) begin
      build_model(words[w], 2, 2'd0, 1'b0);
      for (int k = 0; k < exp_tx.size(); k++) exp_all.push_back(exp_tx[k]);
      exp_all.push_back(1'b1);
      len = exp_tx.size();
    end
    for (int k = 0; k < 3; k++) acc_at[k] = -1;
    wait_ready("back_to_back", ok);
    if (!ok) return;
    cfg_div = 16'd2; cfg_par = 2'd0; cfg_st2 = 1'b0;
    din = words[0]; vin = 1'b1; idx = 0; since = 0; cyc = 0;
    for (int it = 0; it < 66; it++) begin
      rb = (rdy_o === 1'b1);
      @(posedge clk); #1;
      if (rb && vin && idx < 3) begin
        acc_at[idx] = cyc; idx++; since = 0;
        din = 9'($urandom);
        if (idx == 3) vin = 1'b0;
      end else begin
        since++;
      end
      if (since == 4 && idx < 3) din = words[idx];
      @(negedge clk);
      tx_rec.push_back(tx_o === 1'b1);
      fd_rec.push_back(fd_o === 1'b1);
      cyc++;
    end
    vin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (acc_at[k] != k * (len + 1)) begin
        bad++;
        $display("FAIL b2b_accept%0d: accepted at cycle %0d expected %0d", k, acc_at[k], k * (len + 1));
      end
    end
    tx_err = 0; fd_err = 0;
    for (int c = 0; c < tx_rec.size(); c++) begin
      if (tx_rec[c] != ((c < exp_all.size()) ? exp_all[c] : 1'b1)) tx_err++;
      want_fd = (c == len) || (c == 2 * len + 1) || (c == 3 * len + 2);
      if (fd_rec[c] != want_fd) fd_err++;
    end
    total++;
    if (tx_err != 0) begin
      bad++;
      $display("FAIL b2b_tx_wave: %0d wrong cycles, expected 0", tx_err);
    end
    total++;
    if (fd_err != 0) begin
      bad++;
      $display("FAIL b2b_frame_done: %0d wrong cycles, expected 0", fd_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int fd_cnt, low_cnt;
    sel9 = 1'b0;
    build_model(9'h055, 4, 2'd0, 1'b0);
    wait_ready("reset_mid", ok);
    if (!ok) return;
    din = 9'h055; cfg_div = 16'd4; cfg_par = 2'd0; cfg_st2 = 1'b0; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    for (int i = 0; i <= 17; i++) @(negedge clk);
    total++;
    if ({st_o, tx_o} !== {exp_st[17], exp_tx[17]}) begin
      bad++;
      $display("FAIL reset_mid_bit3: {state,tx}=%b expected %b", {st_o, tx_o}, {exp_st[17], exp_tx[17]});
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({tx_o, busy_o, st_o, fd_o, rdy_o} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_mid_abort: {tx,busy,state,done,ready}=%b expected 1000000",
               {tx_o, busy_o, st_o, fd_o, rdy_o});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy_o, st_o, busy_o, fd_o} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_mid_release: {ready,state,busy,done}=%b expected 100000", {rdy_o, st_o, busy_o, fd_o});
    end
    fd_cnt = 0; low_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (fd_o === 1'b1) fd_cnt++;
      if (tx_o !== 1'b1) low_cnt++;
    end
    total++;
    if (fd_cnt != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: %0d frame_done pulses, expected 0", fd_cnt);
    end
    total++;
    if (low_cnt != 0) begin
      bad++;
      $display("FAIL reset_mid_line_idle: tx not high for %0d cycles, expected 0", low_cnt);
    end
  endtask

  task automatic test_basic();
    sel9 = 1'b0;
    run_frame("basic_55", 9'h055, 4, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    sel9 = 1'b0;
    run_frame("even_07", 9'h007, 4, 2'd1, 1'b0, 1'b0);
    run_frame("odd_07",  9'h007, 4, 2'd2, 1'b0, 1'b0);
    run_frame("mark_00", 9'h000, 4, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_stop2();
    sel9 = 1'b0;
    run_frame("stop2_a3_divchg", 9'h0A3, 3, 2'd0, 1'b1, 1'b1);
  endtask

  task automatic test_div_min();
    sel9 = 1'b0;
    run_frame("div0_ff", 9'h0FF, 0, 2'd0, 1'b0, 1'b0);
    run_frame("div1_ff", 9'h0FF, 1, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_width9();
    sel9 = 1'b1;
    run_frame("w9_1ab",      9'h1AB, 2, 2'd0, 1'b0, 1'b0);
    run_frame("w9_1ab_odd2", 9'h1AB, 3, 2'd2, 1'b1, 1'b0);
    sel9 = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      sel9 = (r % 3 == 2);
      run_frame("random", 9'($urandom), int'($urandom_range(0, 6)), 2'($urandom), 1'($urandom), 1'b0);
    end
    sel9 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_div_min();
    test_back_to_back();
    test_reset_mid();
    test_width9();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
